fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_queue.sv | 99 +++++++++
 tb/tb_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: machine width and the fetch queue entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with valid/ready handshakes on both sides and flush.
// Optional same-cycle bypass of an empty queue when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic                       push_v_i,
  input  logic [31:0]                push_instr_i,
  input  logic [XLEN-1:0]            push_pc_i,
  output logic                       push_ready_o,
  output logic                       pop_v_o,
  input  logic                       pop_ready_i,
  output logic [31:0]                pop_instr_o,
  output logic [XLEN-1:0]            pop_pc_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fq_entry_t       mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            push_fire;
  logic            pop_fire;
  logic            write_en;
  fq_entry_t       in_entry;
  fq_entry_t       head;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_entry = '{instr: push_instr_i, pc: push_pc_i};

  assign push_ready_o = ~full;
  assign count_o      = count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming word; it is stored only if DEC does not take it now.
  assign bypass   = empty & push_v_i & pop_ready_i & ~flush_i;
  assign pop_v_o  = (~empty | push_v_i) & ~flush_i;
  assign head     = empty ? in_entry : mem[rd_ptr];
  assign write_en = push_fire & ~bypass;
`else
  assign pop_v_o  = ~empty & ~flush_i;
  assign head     = mem[rd_ptr];
  assign write_en = push_fire;
`endif

  assign pop_instr_o = head.instr;
  assign pop_pc_o    = head.pc;

  assign push_fire = push_v_i & ~full & ~flush_i;
  assign pop_fire  = pop_v_o & pop_ready_i & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({write_en, pop_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, plus directed literal checks.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            flush_i = 1'b0;
  logic            push_v_i = 1'b0;
  logic [31:0]     push_instr_i = '0;
  logic [XLEN-1:0] push_pc_i = '0;
  logic            push_ready_o;
  logic            pop_v_o;
  logic            pop_ready_i = 1'b0;
  logic [31:0]     pop_instr_o;
  logic [XLEN-1:0] pop_pc_o;
  logic [CW-1:0]   count_o;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush_i      (flush_i),
    .push_v_i     (push_v_i),
    .push_instr_i (push_instr_i),
    .push_pc_i    (push_pc_i),
    .push_ready_o (push_ready_o),
    .pop_v_o      (pop_v_o),
    .pop_ready_i  (pop_ready_i),
    .pop_instr_o  (pop_instr_o),
    .pop_pc_o     (pop_pc_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [XLEN-1:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue contents in order, plus whether storage was ever written since reset.
  fq_entry_t mq[$];
  bit        wrote = 1'b0;
  int        m_sz;
  bit        m_v;
  bit        m_byp;
  fq_entry_t m_e;

  function automatic bit exp_valid(input int sz);
`ifdef FETCH_QUEUE_BYPASS_EN
    return (sz != 0 || push_v_i) && !flush_i;
`else
    return (sz != 0) && !flush_i;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      mq.delete();
      wrote = 1'b0;
      chk("rst_count", 64'(count_o), 64'd0);
      chk("rst_pop_v", 64'(pop_v_o), 64'd0);
      chk("rst_push_ready", 64'(push_ready_o), 64'd1);
      chk("rst_pop_instr", 64'(pop_instr_o), 64'd0);
      chk("rst_pop_pc", 64'(pop_pc_o), 64'd0);
    end else begin
      m_sz = mq.size();
      m_v  = exp_valid(m_sz);
      chk("m_count", 64'(count_o), 64'(m_sz));
      chk("m_push_ready", 64'(push_ready_o), 64'(m_sz < DEPTH));
      chk("m_pop_v", 64'(pop_v_o), 64'(m_v));
      if (m_v) begin
        if (m_sz != 0) begin
          chk("m_pop_pc", 64'(pop_pc_o), 64'(mq[0].pc));
          chk("m_pop_instr", 64'(pop_instr_o), 64'(mq[0].instr));
        end else begin
          chk("m_byp_pc", 64'(pop_pc_o), 64'(push_pc_i));
          chk("m_byp_instr", 64'(pop_instr_o), 64'(push_instr_i));
        end
      end else if (!wrote) begin
        chk("m_clean_pc", 64'(pop_pc_o), 64'd0);
        chk("m_clean_instr", 64'(pop_instr_o), 64'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) begin
      m_sz  = mq.size();
      m_byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      m_byp = (m_sz == 0) && push_v_i && pop_ready_i && !flush_i;
`endif
      if (flush_i) begin
        mq.delete();
      end else if (!m_byp) begin
        if (m_sz != 0 && pop_ready_i) void'(mq.pop_front());
        if (push_v_i && m_sz < DEPTH) begin
          m_e.instr = push_instr_i;
          m_e.pc    = push_pc_i;
          mq.push_back(m_e);
          wrote = 1'b1;
        end
      end
    end
  end

  task automatic drive(input bit pv, input logic [XLEN-1:0] pc, input bit pr, input bit fl);
    push_v_i     = pv;
    push_pc_i    = pc;
    push_instr_i = ins_of(pc);
    pop_ready_i  = pr;
    flush_i      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, '0, 0, 0);
    #2;
    chk("in_rst_count", 64'(count_o), 64'd0);
    chk("in_rst_push_ready", 64'(push_ready_o), 64'd1);
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      #2;
      chk("idle_count", 64'(count_o), 64'd0);
      chk("idle_pop_v", 64'(pop_v_o), 64'd0);
      chk("idle_push_ready", 64'(push_ready_o), 64'd1);
      chk("idle_pop_pc", 64'(pop_pc_o), 64'd0);
      tick();
    end

    // Fill past capacity with DEC stalled.
    for (int i = 0; i < 5; i++) begin
      drive(1, XLEN'(4 * i), 0, 0);
      #2;
      chk("fill_push_ready", 64'(push_ready_o), 64'(i < 4));
      chk("fill_count", 64'(count_o), 64'((i < 4) ? i : 4));
      tick();
    end
    drive(0, '0, 0, 0);
    #2;
    chk("full_count", 64'(count_o), 64'd4);
    chk("full_push_ready", 64'(push_ready_o), 64'd0);
    chk("full_head_pc", 64'(pop_pc_o), 64'h0);
    tick();

    // Pop and push together while full: pop happens, push refused.
    drive(1, XLEN'('h14), 1, 0);
    #2;
    chk("fullpp_pop_v", 64'(pop_v_o), 64'd1);
    chk("fullpp_pop_pc", 64'(pop_pc_o), 64'h0);
    chk("fullpp_push_ready", 64'(push_ready_o), 64'd0);
    tick();
    drive(0, '0, 0, 0);
    #2;
    chk("after_pp_count", 64'(count_o), 64'd3);
    chk("after_pp_pop_pc", 64'(pop_pc_o), 64'h4);
    tick();

    drive(0, '0, 1, 0);
    repeat (3) tick();
    drive(0, '0, 0, 0);
    #2;
    chk("drained_count", 64'(count_o), 64'd0);
    tick();

    // Streaming ten entries with DEC always ready.
    for (int k = 0; k <= 10; k++) begin
      drive(k < 10, XLEN'(4 * k), 1, 0);
      #2;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("stream_pop_v", 64'(pop_v_o), 64'(k < 10));
      if (k < 10) chk("stream_pop_pc", 64'(pop_pc_o), 64'(4 * k));
      chk("stream_count", 64'(count_o), 64'd0);
`else
      chk("stream_pop_v", 64'(pop_v_o), 64'(k >= 1));
      if (k >= 1) chk("stream_pop_pc", 64'(pop_pc_o), 64'(4 * (k - 1)));
      chk("stream_count", 64'(count_o), 64'(k >= 1));
`endif
      tick();
    end
    drive(0, '0, 0, 0);
    #2;
    chk("stream_end_count", 64'(count_o), 64'd0);
    tick();

    // Flush with a push in the same cycle.
    for (int i = 0; i < 3; i++) begin
      drive(1, XLEN'('h30 + 4 * i), 0, 0);
      tick();
    end
    drive(1, XLEN'('h100), 1, 1);
    #2;
    chk("flush_pop_v", 64'(pop_v_o), 64'd0);
    chk("flush_count", 64'(count_o), 64'd3);
    tick();
    drive(0, '0, 1, 0);
    #2;
    chk("post_flush_count", 64'(count_o), 64'd0);
    chk("post_flush_pop_v", 64'(pop_v_o), 64'd0);
    tick();
    tick();

    // Push into an empty queue with DEC ready.
    drive(1, XLEN'('h200), 1, 0);
    #2;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_pop_v", 64'(pop_v_o), 64'd1);
    chk("byp_pop_pc", 64'(pop_pc_o), 64'h200);
    chk("byp_count", 64'(count_o), 64'd0);
    tick();
    drive(0, '0, 1, 0);
    #2;
    chk("byp_after_count", 64'(count_o), 64'd0);
    chk("byp_after_pop_v", 64'(pop_v_o), 64'd0);
`else
    chk("nobyp_pop_v", 64'(pop_v_o), 64'd0);
    chk("nobyp_count", 64'(count_o), 64'd0);
    tick();
    drive(0, '0, 1, 0);
    #2;
    chk("nobyp_next_pop_v", 64'(pop_v_o), 64'd1);
    chk("nobyp_next_pop_pc", 64'(pop_pc_o), 64'h200);
    chk("nobyp_next_count", 64'(count_o), 64'd1);
`endif
    tick();
    drive(0, '0, 0, 0);
    #2;
    chk("byp_end_count", 64'(count_o), 64'd0);
    tick();

    // Mixed traffic: irregular push/pop rhythm with one flush, checked by the model.
    for (int c = 0; c < 48; c++) begin
      drive((c % 3) != 2, XLEN'('h400 + 4 * c), (c % 5) < 2, c == 30);
      tick();
    end
    drive(0, '0, 1, 0);
    repeat (DEPTH + 1) tick();

    // Asynchronous reset in the middle of a cycle with entries queued.
    drive(1, XLEN'('h500), 0, 0);
    tick();
    drive(1, XLEN'('h504), 0, 0);
    tick();
    drive(0, '0, 0, 0);
    #2;
    chk("pre_rst_count", 64'(count_o), 64'd2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_pop_v", 64'(pop_v_o), 64'd0);
    chk("async_rst_push_ready", 64'(push_ready_o), 64'd1);
    tick();
    tick();
    reset_n = 1'b1;
    drive(0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("post_rst_pop_v", 64'(pop_v_o), 64'd0);
      chk("post_rst_pop_pc", 64'(pop_pc_o), 64'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
